// File: rtl/issue_queue.sv
// issue_queue: 16-entry out-of-order issue queue.
// Holds dispatched instructions until both sources are ready, exposes
// per-entry op/req/age vectors to an external age-based arbiter, and turns
// the arbiter's grant into a registered one-cycle issue packet.
//
// Handshake: a dispatch transfers on a rising edge where disp_valid and
// disp_ready are both high; disp_ready depends only on registered state and
// rst. An issue fires on an edge where grant is high and the addressed entry
// is requesting; a grant to a non-requesting entry is ignored.
module issue_queue #(
  parameter int OPCODE_WIDTH  = 7,
  parameter int AGE_WIDTH     = 5,
  parameter int PRF_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OPCODE_WIDTH-1:0]    disp_op,
  input  logic [PRF_WIDTH-1:0]       disp_prd,
  input  logic [PRF_WIDTH-1:0]       disp_prs1,
  input  logic [PRF_WIDTH-1:0]       disp_prs2,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [PAYLOAD_WIDTH-1:0]   disp_payload,
  input  logic [1:0]                 wb_valid,
  input  logic [PRF_WIDTH-1:0]       wb_prd0,
  input  logic [PRF_WIDTH-1:0]       wb_prd1,
  output logic [16*OPCODE_WIDTH-1:0] iq_op,
  output logic [15:0]                iq_req,
  output logic [16*AGE_WIDTH-1:0]    iq_age,
  input  logic                       grant,
  input  logic [3:0]                 addr,
  output logic                       iss_valid,
  output logic [OPCODE_WIDTH-1:0]    iss_op,
  output logic [PRF_WIDTH-1:0]       iss_prd,
  output logic [PRF_WIDTH-1:0]       iss_prs1,
  output logic [PRF_WIDTH-1:0]       iss_prs2,
  output logic [PAYLOAD_WIDTH-1:0]   iss_payload
);

  logic [15:0]              r_valid;
  logic [15:0]              r_rs1_rdy;
  logic [15:0]              r_rs2_rdy;
  logic [OPCODE_WIDTH-1:0]  r_op      [16];
  logic [PRF_WIDTH-1:0]     r_prd     [16];
  logic [PRF_WIDTH-1:0]     r_prs1    [16];
  logic [PRF_WIDTH-1:0]     r_prs2    [16];
  logic [PAYLOAD_WIDTH-1:0] r_payload [16];
  logic [AGE_WIDTH-1:0]     r_age     [16];
  logic [4:0]               r_count;

  logic                     r_iss_valid;
  logic [OPCODE_WIDTH-1:0]  r_iss_op;
  logic [PRF_WIDTH-1:0]     r_iss_prd;
  logic [PRF_WIDTH-1:0]     r_iss_prs1;
  logic [PRF_WIDTH-1:0]     r_iss_prs2;
  logic [PAYLOAD_WIDTH-1:0] r_iss_payload;

  logic                     w_fire;
  logic                     w_alloc;
  logic [3:0]               w_slot;
  logic [AGE_WIDTH-1:0]     w_fire_age;
  logic [AGE_WIDTH-1:0]     w_new_age;
  logic                     w_new_rs1_rdy;
  logic                     w_new_rs2_rdy;

  // True when either writeback port broadcasts the given tag this cycle.
  function automatic logic tag_hit(input logic [PRF_WIDTH-1:0] tag);
    return (wb_valid[0] && (wb_prd0 == tag)) || (wb_valid[1] && (wb_prd1 == tag));
  endfunction

  assign disp_ready    = ~rst & (r_count != 5'd16);
  assign w_alloc       = disp_valid & disp_ready;
  assign w_fire        = grant & iq_req[addr];
  assign w_fire_age    = r_age[addr];
  assign w_new_age     = AGE_WIDTH'(r_count - {4'd0, w_fire});
  assign w_new_rs1_rdy = disp_rs1_rdy | tag_hit(disp_prs1);
  assign w_new_rs2_rdy = disp_rs2_rdy | tag_hit(disp_prs2);

  assign iss_valid   = r_iss_valid;
  assign iss_op      = r_iss_op;
  assign iss_prd     = r_iss_prd;
  assign iss_prs1    = r_iss_prs1;
  assign iss_prs2    = r_iss_prs2;
  assign iss_payload = r_iss_payload;

  // Lowest-index free slot: scan downward so the smallest index wins.
  always_comb begin
    w_slot = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!r_valid[i]) w_slot = 4'(i);
    end
  end

  // Arbiter-facing vectors, flattened with entry i at [i*W +: W].
  always_comb begin
    iq_req = '0;
    iq_op  = '0;
    iq_age = '0;
    for (int i = 0; i < 16; i++) begin
      iq_req[i]                         = r_valid[i] & r_rs1_rdy[i] & r_rs2_rdy[i];
      iq_op[i*OPCODE_WIDTH +: OPCODE_WIDTH] = r_op[i];
      iq_age[i*AGE_WIDTH +: AGE_WIDTH]  = r_age[i];
    end
  end

  // Entry state, occupancy count and issue packet; flush/rst discard
  // any same-cycle dispatch, wakeup or fire.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      if (rst) begin
        r_rs1_rdy     <= '0;
        r_rs2_rdy     <= '0;
        r_iss_op      <= '0;
        r_iss_prd     <= '0;
        r_iss_prs1    <= '0;
        r_iss_prs2    <= '0;
        r_iss_payload <= '0;
        for (int i = 0; i < 16; i++) begin
          r_op[i]      <= '0;
          r_prd[i]     <= '0;
          r_prs1[i]    <= '0;
          r_prs2[i]    <= '0;
          r_payload[i] <= '0;
          r_age[i]     <= '0;
        end
      end
    end else begin
      r_iss_valid <= w_fire;
      if (w_fire) begin
        r_iss_op      <= r_op[addr];
        r_iss_prd     <= r_prd[addr];
        r_iss_prs1    <= r_prs1[addr];
        r_iss_prs2    <= r_prs2[addr];
        r_iss_payload <= r_payload[addr];
      end
      r_count <= r_count + 5'(w_alloc) - 5'(w_fire);
      for (int i = 0; i < 16; i++) begin
        if (r_valid[i]) begin
          if (tag_hit(r_prs1[i])) r_rs1_rdy[i] <= 1'b1;
          if (tag_hit(r_prs2[i])) r_rs2_rdy[i] <= 1'b1;
          // Close the age gap left by the issuing entry.
          if (w_fire && (r_age[i] > w_fire_age)) r_age[i] <= r_age[i] - 1'b1;
        end
        if (w_fire && (addr == 4'(i))) r_valid[i] <= 1'b0;
        // The allocated slot is invalid, so it never collides with the fired one.
        if (w_alloc && (w_slot == 4'(i))) begin
          r_valid[i]   <= 1'b1;
          r_op[i]      <= disp_op;
          r_prd[i]     <= disp_prd;
          r_prs1[i]    <= disp_prs1;
          r_prs2[i]    <= disp_prs2;
          r_rs1_rdy[i] <= w_new_rs1_rdy;
          r_rs2_rdy[i] <= w_new_rs2_rdy;
          r_payload[i] <= disp_payload;
          r_age[i]     <= w_new_age;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue.
module tb_issue_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         disp_valid;
  logic         disp_ready;
  logic [6:0]   disp_op;
  logic [5:0]   disp_prd;
  logic [5:0]   disp_prs1;
  logic [5:0]   disp_prs2;
  logic         disp_rs1_rdy;
  logic         disp_rs2_rdy;
  logic [63:0]  disp_payload;
  logic [1:0]   wb_valid;
  logic [5:0]   wb_prd0;
  logic [5:0]   wb_prd1;
  logic [111:0] iq_op;
  logic [15:0]  iq_req;
  logic [79:0]  iq_age;
  logic         grant;
  logic [3:0]   addr;
  logic         iss_valid;
  logic [6:0]   iss_op;
  logic [5:0]   iss_prd;
  logic [5:0]   iss_prs1;
  logic [5:0]   iss_prs2;
  logic [63:0]  iss_payload;

  int n_checks = 0;
  int n_errors = 0;

  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_prd(disp_prd),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_prd0(wb_prd0), .wb_prd1(wb_prd1),
    .iq_op(iq_op), .iq_req(iq_req), .iq_age(iq_age),
    .grant(grant), .addr(addr),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_prd(iss_prd),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_payload(iss_payload)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] age_of(input int i);
    return iq_age[i*5 +: 5];
  endfunction

  function automatic logic [6:0] op_of(input int i);
    return iq_op[i*7 +: 7];
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [6:0] op, input logic [5:0] prd, input logic [5:0] p1,
                          input logic [5:0] p2, input logic r1, input logic r2, input logic [63:0] pl);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_prd     = prd;
    disp_prs1    = p1;
    disp_prs2    = p2;
    disp_rs1_rdy = r1;
    disp_rs2_rdy = r2;
    disp_payload = pl;
  endtask

  // Fully ready op whose fields are derived from the expected slot number.
  task automatic set_rdy(input int s);
    set_disp(7'(10 + s), 6'(s), 6'(20 + s), 6'(40 + s), 1'b1, 1'b1, 64'hC0DE_0000_0000_0100 + 64'(s));
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 2'b00;
    grant      = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_prd = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    disp_payload = '0; wb_valid = '0; wb_prd0 = '0; wb_prd1 = '0; grant = 1'b0; addr = '0;

    // Reset state
    step(); step();
    chk("rst_disp_ready", 128'(disp_ready), 128'd0);
    chk("rst_iq_req", 128'(iq_req), 128'h0);
    chk("rst_iq_age", 128'(iq_age), 128'h0);
    chk("rst_iq_op", 128'(iq_op), 128'h0);
    chk("rst_iss_valid", 128'(iss_valid), 128'd0);
    chk("rst_iss_payload", 128'(iss_payload), 128'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_disp_ready", 128'(disp_ready), 128'd1);

    // Three ready ops into an empty queue
    for (int s = 0; s < 3; s++) begin
      set_rdy(s);
      step();
    end
    idle();
    chk("three_req", 128'(iq_req), 128'h0007);
    chk("three_age0", 128'(age_of(0)), 128'd0);
    chk("three_age1", 128'(age_of(1)), 128'd1);
    chk("three_age2", 128'(age_of(2)), 128'd2);
    chk("three_op2", 128'(op_of(2)), 128'd12);
    chk("three_ready", 128'(disp_ready), 128'd1);

    // Slot 3 waits on tag 5, woken by a later broadcast
    set_disp(7'h33, 6'd33, 6'd5, 6'd40, 1'b0, 1'b1, 64'h3333);
    step(); idle();
    chk("wait_req_a", 128'(iq_req), 128'h0007);
    step();
    chk("wait_req_b", 128'(iq_req), 128'h0007);
    wb_valid = 2'b01; wb_prd0 = 6'd5;
    step(); idle();
    chk("wake_req", 128'(iq_req), 128'h000F);

    // Same-cycle dispatch and broadcast on both ports: ready on arrival
    set_disp(7'h44, 6'd44, 6'd5, 6'd9, 1'b0, 1'b0, 64'h4444);
    wb_valid = 2'b11; wb_prd0 = 6'd5; wb_prd1 = 6'd9;
    step(); idle();
    chk("bypass_req", 128'(iq_req), 128'h001F);

    // Slot 5 waits on tag 7, never broadcast
    set_disp(7'h45, 6'd45, 6'd7, 6'd41, 1'b0, 1'b1, 64'h4545);
    step(); idle();
    chk("nowake_req", 128'(iq_req), 128'h001F);

    // Grant to a non-requesting entry is ignored
    grant = 1'b1; addr = 4'd5;
    step(); idle();
    chk("badgrant_iss_valid", 128'(iss_valid), 128'd0);
    chk("badgrant_req", 128'(iq_req), 128'h001F);
    chk("badgrant_age5", 128'(age_of(5)), 128'd5);
    chk("badgrant_age4", 128'(age_of(4)), 128'd4);

    // Fill remaining slots 6..15
    for (int s = 6; s < 16; s++) begin
      set_rdy(s);
      step();
    end
    idle();
    chk("full_ready", 128'(disp_ready), 128'd0);
    chk("full_req", 128'(iq_req), 128'hFFDF);
    chk("full_age15", 128'(age_of(15)), 128'd15);

    // Full: dispatch held off while slot 3 fires
    set_disp(7'h55, 6'd55, 6'd1, 6'd2, 1'b1, 1'b1, 64'h5555);
    grant = 1'b1; addr = 4'd3;
    #1;
    chk("full_fire_ready", 128'(disp_ready), 128'd0);
    step();
    grant = 1'b0;
    chk("fire_iss_valid", 128'(iss_valid), 128'd1);
    chk("fire_iss_op", 128'(iss_op), 128'h33);
    chk("fire_iss_prd", 128'(iss_prd), 128'd33);
    chk("fire_iss_prs1", 128'(iss_prs1), 128'd5);
    chk("fire_iss_prs2", 128'(iss_prs2), 128'd40);
    chk("fire_iss_payload", 128'(iss_payload), 128'h3333);
    chk("fire_req", 128'(iq_req), 128'hFFD7);
    chk("fire_age15", 128'(age_of(15)), 128'd14);
    chk("fire_age4", 128'(age_of(4)), 128'd3);
    chk("fire_age2", 128'(age_of(2)), 128'd2);
    chk("fire_ready", 128'(disp_ready), 128'd1);
    step(); idle();
    chk("refill_iss_valid", 128'(iss_valid), 128'd0);
    chk("refill_age3", 128'(age_of(3)), 128'd15);
    chk("refill_op3", 128'(op_of(3)), 128'h55);
    chk("refill_req", 128'(iq_req), 128'hFFDF);
    chk("refill_ready", 128'(disp_ready), 128'd0);

    // Empty the queue, then hold 10 entries
    flush = 1'b1;
    step(); idle();
    chk("flush1_req", 128'(iq_req), 128'h0);
    for (int s = 0; s < 10; s++) begin
      set_rdy(s);
      step();
    end
    idle();
    chk("ten_req", 128'(iq_req), 128'h03FF);

    // Flush with concurrent dispatch and a valid grant: all discarded
    set_rdy(10);
    grant = 1'b1; addr = 4'd0; flush = 1'b1;
    step(); idle();
    chk("flush_req", 128'(iq_req), 128'h0);
    chk("flush_iss_valid", 128'(iss_valid), 128'd0);
    chk("flush_ready", 128'(disp_ready), 128'd1);
    set_rdy(0);
    step(); idle();
    chk("postflush_req", 128'(iq_req), 128'h0001);
    chk("postflush_age0", 128'(age_of(0)), 128'd0);

    // count=4, then dispatch and fire the age-1 entry together
    for (int s = 1; s < 4; s++) begin
      set_rdy(s);
      step();
    end
    idle();
    chk("four_req", 128'(iq_req), 128'h000F);
    set_rdy(4);
    grant = 1'b1; addr = 4'd1;
    step(); idle();
    chk("mix_iss_valid", 128'(iss_valid), 128'd1);
    chk("mix_iss_payload", 128'(iss_payload), 128'hC0DE_0000_0000_0101);
    chk("mix_req", 128'(iq_req), 128'h001D);
    chk("mix_age0", 128'(age_of(0)), 128'd0);
    chk("mix_age2", 128'(age_of(2)), 128'd1);
    chk("mix_age3", 128'(age_of(3)), 128'd2);
    chk("mix_age4", 128'(age_of(4)), 128'd3);
    step();
    chk("mix_iss_drop", 128'(iss_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

16-entry out-of-order issue queue that holds dispatched instructions until both source operands are ready, then presents per-entry opcode, request and age vectors to the age-based issue arbiter. It consumes the arbiter's grant/addr, registers the selected entry into an issue packet for the execution stage, and frees the slot. Writeback tag broadcasts wake up waiting sources. A flush clears the whole queue.

## Interface
- OPCODE_WIDTH, 7, instruction-class opcode compared by the arbiter
- AGE_WIDTH, 5, per-entry age; 0 = oldest
- PRF_WIDTH, 6, physical register tag width
- PAYLOAD_WIDTH, 64, opaque bits carried through (imm, funct, pc, rob id)
- Depth fixed at 16 (addr 4 bits)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  clear all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  slot available
- disp_op  in  OPCODE_WIDTH
- disp_prd / disp_prs1 / disp_prs2  in  PRF_WIDTH each
- disp_rs1_rdy / disp_rs2_rdy  in  1 each  source already available at rename
- disp_payload  in  PAYLOAD_WIDTH
- wb_valid  in  2  writeback broadcast valid, one bit per port
- wb_prd0 / wb_prd1  in  PRF_WIDTH  broadcast tags
- iq_op  out  OPCODE_WIDTH x16  entry opcode to arbiter
- iq_req  out  16  entry valid & both sources ready
- iq_age  out  AGE_WIDTH x16  entry age to arbiter
- grant  in  1  arbiter selected an entry
- addr  in  4  selected entry index
- iss_valid  out  1  issue packet valid
- iss_op, iss_prd, iss_prs1, iss_prs2, iss_payload  out  issue packet fields

## Operation
- Entry state: valid, op, prd, prs1, rs1_rdy, prs2, rs2_rdy, payload, age. count = number of valid entries (0..16).
- disp_ready = ~rst & (count < 16); computed from current state only, not from a same-cycle issue.
- Allocate when disp_valid & disp_ready: slot = lowest-index invalid entry.
- New source ready bit = disp_rsX_rdy | (wb_valid[0] & wb_prd0==prsX) | (wb_valid[1] & wb_prd1==prsX).
- Wakeup: each valid entry sets rsX_rdy when a valid broadcast tag equals prsX. Ready bits never clear except by freeing.
- iq_req[i] = valid[i] & rs1_rdy[i] & rs2_rdy[i]; iq_op/iq_age driven from entry registers (invalid entries: op and age hold last value, req 0).
- Issue fires when grant & iq_req[addr]; otherwise grant ignored. Fire: entry addr invalidated, its fields captured into issue packet register.
- Ages unique in 0..count-1. On fire, every valid entry with age > age[addr] decrements by 1. New entry age = count - fire.
- count_next = count + alloc - fire.
- flush: all valid cleared, count 0, iss_valid 0 next cycle; dispatch, wakeup and fire in the same cycle are discarded. rst has identical effect plus clears iss_* fields to 0.

## Timing
- Reset values: valid all 0, count 0, iq_req 0, iq_age 0, iq_op 0, iss_valid 0, iss_* 0; disp_ready 0 during rst, 1 the cycle after.
- Dispatch at edge t: entry visible (iq_req if ready) from cycle t+1.
- Wakeup broadcast in cycle t: iq_req rises in cycle t+1.
- Fire in cycle t: iss_valid=1 with packet in cycle t+1, one cycle only; entry iq_req=0 in t+1.
- Full: count=16 → disp_ready=0 even if a fire occurs that cycle; slot usable next cycle.
- Simultaneous alloc + fire: both applied; allocated slot never equals fired slot (alloc uses invalid slot).
- Broadcast to a slot being allocated in the same cycle is captured via dispatch bypass rule.
- Throughput: 1 dispatch and 1 issue per cycle.

## Test plan
- Reset then dispatch 3 ready ops to empty queue -> slots 0,1,2, ages 0,1,2, iq_req=16'h0007 next cycle; disp_ready=1.
- Dispatch entry with prs1=5 not ready; wb_valid=2'b01, wb_prd0=5 two cycles later -> iq_req bit rises the cycle after broadcast; same-cycle dispatch+broadcast of tag 5 -> ready on arrival.
- Fill 16 entries -> disp_ready=0; grant addr=3 -> iss_valid next cycle with slot 3 fields, ages above old age[3] decrement, disp_ready=1, next dispatch lands in slot 3 with age 15.
- Same cycle dispatch and fire with count=4, fire on age 1 -> new entry age 3, count stays 4, ages remain unique 0..3.
- grant=1 with addr pointing to non-ready entry -> no issue, no state change.
- flush with 10 valid entries plus concurrent dispatch and grant -> next cycle count 0, iq_req 0, iss_valid 0.
